// File: rtl/cpu_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder_if
// Description : Unified instruction/data memory port bundle (request side
//               driven by the CPU, response side driven by the memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_mem_responder_if;
    logic [31:0] address;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        misaligned;

    modport master (
        output address, wr, wdata,
        input  rdata, rvalid, misaligned
    );

    modport slave (
        input  address, wr, wdata,
        output rdata, rvalid, misaligned
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder
// Description : Byte-addressed little-endian word memory with a fixed-latency
//               read pipeline, read-valid strobe and misalignment flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder #(
    parameter int DEPTH_BYTES  = 256,
    parameter int READ_LATENCY = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    cpu_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0]    mem_q [DEPTH_BYTES];

    logic [AW-1:0] base_w;
    logic [AW-1:0] byte_addr_w [4];
    logic [31:0]   rd_word_w;

    logic          stage_valid_w;
    logic [31:0]   stage_data_w;

    logic [31:0]   rdata_q;
    logic [31:0]   rdata_d;
    logic          rvalid_q;
    logic          misaligned_q;

    // AW-bit address arithmetic gives the wrap past the top byte for free.
    always_comb begin
        base_w    = bus.address[AW-1:0];
        rd_word_w = '0;
        for (int k = 0; k < 4; k++) begin
            byte_addr_w[k]       = base_w + AW'(k);
            rd_word_w[8*k +: 8]  = mem_q[byte_addr_w[k]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && bus.wr) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[byte_addr_w[k]] <= bus.wdata[8*k +: 8];
            end
        end
    end

    // Stages ahead of the output register; the output register is the last stage.
    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign stage_valid_w = !bus.wr;
            assign stage_data_w  = rd_word_w;
        end else begin : g_pipe
            localparam int N = READ_LATENCY - 1;
            logic [N-1:0] valid_q;
            logic [31:0]  data_q [N];

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= '0;
                    for (int i = 0; i < N; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q[0] <= !bus.wr;
                    data_q[0]  <= rd_word_w;
                    for (int i = 1; i < N; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign stage_valid_w = valid_q[N-1];
            assign stage_data_w  = data_q[N-1];
        end
    endgenerate

    always_comb begin
        rdata_d = rdata_q;
        if (stage_valid_w) begin
            rdata_d = stage_data_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            rdata_q      <= rdata_d;
            rvalid_q     <= stage_valid_w;
            misaligned_q <= (bus.address[1:0] != 2'b00);
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.misaligned = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_responder
// Description : Directed bench; four responders (READ_LATENCY 1..4) share one
//               request stream, each checked against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;

    int n_checks;
    int n_errors;

    cpu_mem_responder_if bus [4] ();

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            assign bus[g].address = addr;
            assign bus[g].wr      = wr;
            assign bus[g].wdata   = wdata;

            cpu_mem_responder #(
                .DEPTH_BYTES  (256),
                .READ_LATENCY (g + 1)
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access sampled at the next rising edge; returns just after that edge.
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        wr    = w;
        addr  = a;
        wdata = d;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        wr       = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        tick();
        tick();
        check("rst_rdata_l1",  bus[0].rdata, 32'h0);
        check("rst_rvalid_l1", {31'b0, bus[0].rvalid}, 32'h0);
        check("rst_mis_l1",    {31'b0, bus[0].misaligned}, 32'h0);
        check("rst_rdata_l4",  bus[3].rdata, 32'h0);
        check("rst_rvalid_l4", {31'b0, bus[3].rvalid}, 32'h0);
        reset = 1'b0;

        // Write then read, aligned and misaligned
        step(1'b1, 32'h14, 32'h0000_0010);
        step(1'b1, 32'h10, 32'hDEAD_BEEF);
        check("wr_slot_rvalid", {31'b0, bus[0].rvalid}, 32'h0);
        check("wr_aligned_mis", {31'b0, bus[0].misaligned}, 32'h0);
        step(1'b0, 32'h10, 32'h0);
        check("rd10_rdata",  bus[0].rdata, 32'hDEAD_BEEF);
        check("rd10_rvalid", {31'b0, bus[0].rvalid}, 32'h1);
        check("rd10_l2_early", {31'b0, bus[1].rvalid}, 32'h0);
        step(1'b0, 32'h11, 32'h0);
        check("rd11_rdata", bus[0].rdata, 32'h10DE_ADBE);
        check("rd11_mis",   {31'b0, bus[0].misaligned}, 32'h1);
        check("rd10_l2_rdata",  bus[1].rdata, 32'hDEAD_BEEF);
        check("rd10_l2_rvalid", {31'b0, bus[1].rvalid}, 32'h1);

        // Write slot bubbles: rdata holds during write cycles
        step(1'b1, 32'h40, 32'h0102_0304);
        check("bub1_rvalid", {31'b0, bus[0].rvalid}, 32'h0);
        check("bub1_hold",   bus[0].rdata, 32'h10DE_ADBE);
        check("bub1_mis",    {31'b0, bus[0].misaligned}, 32'h0);
        step(1'b0, 32'h40, 32'h0);
        check("bub2_rdata",  bus[0].rdata, 32'h0102_0304);
        check("bub2_rvalid", {31'b0, bus[0].rvalid}, 32'h1);
        step(1'b1, 32'h44, 32'hCAFE_F00D);
        check("bub3_rvalid", {31'b0, bus[0].rvalid}, 32'h0);
        check("bub3_hold",   bus[0].rdata, 32'h0102_0304);
        step(1'b0, 32'h44, 32'h0);
        check("bub4_rdata",  bus[0].rdata, 32'hCAFE_F00D);

        // Streaming reads, latency 3
        step(1'b1, 32'h00, 32'hA0A0_A0A0);
        step(1'b1, 32'h04, 32'hB1B1_B1B1);
        step(1'b1, 32'h08, 32'hC2C2_C2C2);
        step(1'b0, 32'h00, 32'h0);
        check("str_e1_rvalid", {31'b0, bus[2].rvalid}, 32'h0);
        step(1'b0, 32'h04, 32'h0);
        check("str_e2_rvalid", {31'b0, bus[2].rvalid}, 32'h0);
        step(1'b0, 32'h08, 32'h0);
        check("str_e3_rvalid", {31'b0, bus[2].rvalid}, 32'h1);
        check("str_e3_rdata",  bus[2].rdata, 32'hA0A0_A0A0);
        step(1'b1, 32'h80, 32'h0);
        check("str_e4_rvalid", {31'b0, bus[2].rvalid}, 32'h1);
        check("str_e4_rdata",  bus[2].rdata, 32'hB1B1_B1B1);
        step(1'b1, 32'h80, 32'h0);
        check("str_e5_rvalid", {31'b0, bus[2].rvalid}, 32'h1);
        check("str_e5_rdata",  bus[2].rdata, 32'hC2C2_C2C2);
        step(1'b1, 32'h80, 32'h0);
        check("str_e6_rvalid", {31'b0, bus[2].rvalid}, 32'h0);
        check("str_e6_hold",   bus[2].rdata, 32'hC2C2_C2C2);

        // Top-of-memory wrap and address aliasing
        step(1'b1, 32'hFE, 32'h1122_3344);
        check("wrap_wr_mis", {31'b0, bus[0].misaligned}, 32'h1);
        step(1'b0, 32'hFE, 32'h0);
        check("wrap_rd_fe", bus[0].rdata, 32'h1122_3344);
        step(1'b0, 32'h1FE, 32'h0);
        check("wrap_rd_1fe", bus[0].rdata, 32'h1122_3344);
        step(1'b0, 32'h00, 32'h0);
        check("wrap_rd_00", bus[0].rdata, 32'hA0A0_1122);
        step(1'b0, 32'hFF, 32'h0);
        check("wrap_rd_ff", bus[0].rdata, 32'hA011_2233);

        // Read/write hazard, latency 2
        step(1'b1, 32'h20, 32'hAAAA_AAAA);
        step(1'b0, 32'h20, 32'h0);
        step(1'b1, 32'h20, 32'h5555_5555);
        check("haz_old_rdata",  bus[1].rdata, 32'hAAAA_AAAA);
        check("haz_old_rvalid", {31'b0, bus[1].rvalid}, 32'h1);
        step(1'b0, 32'h20, 32'h0);
        check("haz_bub_rvalid", {31'b0, bus[1].rvalid}, 32'h0);
        check("haz_new_l1",     bus[0].rdata, 32'h5555_5555);
        step(1'b1, 32'h84, 32'h0);
        check("haz_new_l2",     bus[1].rdata, 32'h5555_5555);
        check("haz_new_rvalid", {31'b0, bus[1].rvalid}, 32'h1);

        // Reset mid-flight, latency 4; write during reset is discarded
        step(1'b1, 32'h30, 32'h1234_5678);
        step(1'b0, 32'h00, 32'h0);
        step(1'b0, 32'h04, 32'h0);
        reset = 1'b1;
        step(1'b1, 32'h30, 32'hFFFF_FFFF);
        reset = 1'b0;
        check("midrst_rvalid", {31'b0, bus[3].rvalid}, 32'h0);
        check("midrst_rdata",  bus[3].rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h88, 32'h0);
            check("post_rst_rvalid", {31'b0, bus[3].rvalid}, 32'h0);
        end
        check("post_rst_rdata", bus[3].rdata, 32'h0);
        step(1'b0, 32'h30, 32'h0);
        check("rst_wr_drop_l1", bus[0].rdata, 32'h1234_5678);
        check("l4_early", {31'b0, bus[3].rvalid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h8C, 32'h0);
        end
        check("rst_wr_drop_l4", bus[3].rdata, 32'h1234_5678);
        check("l4_rvalid",      {31'b0, bus[3].rvalid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
